// File: rtl/seq_alu.sv
// Multi-cycle ALU for the femtoRV32 execute stage: valid/ready in and out, bit-serial shifts.
// Define SEQ_ALU_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shift.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             sf,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds its data stable from raising valid until that edge.
  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_cf, r_vf;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cf, w_vf;
  logic [SHW-1:0]   w_amt;
  logic             w_accept;

  assign w_amt    = op_b[SHW-1:0];
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_comb begin
    w_sub = (alu_sel == ALU_SUB);
    w_sum = {1'b0, op_a} + {1'b0, (w_sub ? ~op_b : op_b)} + {{WIDTH{1'b0}}, w_sub};
    w_res = '0;
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_PASS: w_res = op_b;
      ALU_OR:   w_res = op_a | op_b;
      ALU_AND:  w_res = op_a & op_b;
      ALU_XOR:  w_res = op_a ^ op_b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      ALU_SRL:  w_res = op_a >> w_amt;
      ALU_SLL:  w_res = op_a << w_amt;
      ALU_SRA:  w_res = $signed(op_a) >>> w_amt;
`else
      // Serial build: loads op_a, which is also the final answer for a zero shift amount.
      ALU_SRL, ALU_SLL, ALU_SRA: w_res = op_a;
`endif
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default:  w_res = '0;
    endcase
  end

`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] w_step;
  logic             w_is_shift;

  assign w_is_shift = (alu_sel == ALU_SRL) || (alu_sel == ALU_SLL) || (alu_sel == ALU_SRA);

  always_comb begin
    w_step = r_result;
    case (r_sel)
      ALU_SRL: w_step = {1'b0, r_result[WIDTH-1:1]};
      ALU_SLL: w_step = {r_result[WIDTH-2:0], 1'b0};
      ALU_SRA: w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default: w_step = r_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (w_accept) begin
      r_cnt <= w_amt;
      r_sel <= alu_sel;
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= r_cnt - SHW'(1);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
          w_state_nxt = ST_DONE;
`else
          w_state_nxt = (w_is_shift && (w_amt != '0)) ? ST_SHIFT : ST_DONE;
`endif
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      ST_SHIFT: if (r_cnt == SHW'(1)) w_state_nxt = ST_DONE;
`endif
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cf     <= 1'b0;
      r_vf     <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_res;
      r_cf     <= w_cf;
      r_vf     <= w_vf;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_step;
`endif
    end
  end

  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zf        = (r_result == '0);
  assign sf        = r_result[WIDTH-1];
  assign cf        = r_cf;
  assign vf        = r_vf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: behavioural model feeding an expected queue, plus literal pins.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zf, cf, vf, sf;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Expected {result, zf, cf, vf, sf} from the ISA meaning of each code.
  function automatic logic [35:0] model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    longint      sa, sb, s;
    int          n;
    r = '0; c = 1'b0; v = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = int'(b[4:0]);
    case (sel)
      4'b0000: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0011: r = b;
      4'b0100: r = a | b;
      4'b0101: r = a & b;
      4'b0111: r = a ^ b;
      4'b1000: r = a >> n;
      4'b1001: r = a << n;
      4'b1010: r = $signed(a) >>> n;
      4'b1101: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: r = (a < b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r, (r == 32'd0), c, v, r[31]};
  endfunction

  function automatic int exp_lat(input logic [3:0] sel, input logic [31:0] b);
`ifdef SEQ_ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((sel == 4'b1000 || sel == 4'b1001 || sel == 4'b1010) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Compare every cycle the output is valid; retire on the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
      else chk("result_flags", {28'd0, result, zf, cf, vf, sf}, {28'd0, exp_q[0]});
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int w;
    int lat;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    alu_sel = sel;
    op_a = a;
    op_b = b;
    exp_q.push_back(model(sel, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    alu_sel = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat(sel, b)));
  endtask

  task automatic release_out(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_sel = 4'b0000;
      op_a = $urandom;
      op_b = $urandom;
      chk("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid_low", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready_high", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {60'd0, zf, cf, vf, sf}, 64'b1000);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(4'b0000, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_result", {32'd0, result}, 64'h8000_0000);
    chk("add_ovf_flags", {60'd0, zf, cf, vf, sf}, 64'b0011);
    release_out(0);

    issue(4'b0001, 32'h1234_5678, 32'h1234_5678);
    chk("sub_eq_result", {32'd0, result}, 64'd0);
    chk("sub_eq_flags", {60'd0, zf, cf, vf, sf}, 64'b1100);
    release_out(0);

    issue(4'b1111, 32'd1, 32'hFFFF_FFFF);
    chk("sltu_result", {32'd0, result}, 64'd1);
    release_out(0);

    issue(4'b1010, 32'h8000_0000, 32'd4);
    chk("sra4_result", {32'd0, result}, 64'hF800_0000);
    release_out(0);

    issue(4'b1010, 32'h8000_0000, 32'd0);
    chk("sra0_result", {32'd0, result}, 64'h8000_0000);
    release_out(0);

    issue(4'b0111, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    chk("xor_result", {32'd0, result}, 64'hAAAA_AAAA);
    release_out(10);
    issue(4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("and_after_bp", {32'd0, result}, 64'h0F00_0F00);
    release_out(0);

    issue(4'b0110, 32'd5, 32'd3);
    chk("undef_result", {32'd0, result}, 64'd0);
    chk("undef_zf", {63'd0, zf}, 64'd1);
    release_out(0);

    issue(4'b1001, 32'd1, 32'd31);
    chk("sll31_result", {32'd0, result}, 64'h8000_0000);
    release_out(0);

    issue(4'b0001, 32'd3, 32'd5);
    release_out(1);
    issue(4'b0001, 32'h8000_0000, 32'd1);
    release_out(0);
    issue(4'b1101, 32'hFFFF_FFFE, 32'd3);
    chk("slt_neg_result", {32'd0, result}, 64'd1);
    release_out(0);
    issue(4'b1000, 32'hF000_0001, 32'd3);
    release_out(0);
    issue(4'b0011, 32'h1111_1111, 32'hDEAD_BEEF);
    release_out(2);
    issue(4'b0100, 32'h00F0_0000, 32'h0000_000F);
    release_out(0);
    issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_carry_flags", {60'd0, zf, cf, vf, sf}, 64'b1100);
    release_out(0);

    // Abandon a long serial shift with reset.
    @(negedge clk);
    in_valid = 1'b1;
    alu_sel = 4'b1001;
    op_a = 32'd1;
    op_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_result", {32'd0, result}, 64'd0);
    chk("midrst_zf", {63'd0, zf}, 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    issue(4'b0011, 32'd0, 32'h0000_00AB);
    chk("post_rst_pass", {32'd0, result}, 64'h0000_00AB);
    release_out(0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle ALU that executes the 4-bit ALU selection code produced by the ALU control unit. It is the consumer end of the ALU_Selection interface.
- Sits in the execute stage of the femtoRV32 multicycle datapath. Takes operands and selection through a valid/ready handshake.
- Shifts execute bit-serially, one bit per cycle. All other ops complete in one cycle.
- Result and flags (zero, carry, overflow, sign) are held until the consumer accepts them.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width in bits; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and selection valid.
- in_ready  output  1  block can accept an operation.
- alu_sel  input  4  ALU selection code, encoded per the `ALU_* defines.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B; shifts use op_b[SHW-1:0] as the shift amount.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zf  output  1  zero flag: result == 0.
- cf  output  1  carry out of the ADD/SUB adder; 0 for all other ops.
- vf  output  1  signed overflow of ADD/SUB; 0 for all other ops.
- sf  output  1  result[WIDTH-1].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, result=0, zf=1, cf=0, vf=0, sf=0, out_valid=0.
  - in_ready goes to 1 as soon as rst_n deasserts.
  - Reset mid-operation abandons the operation; no output is produced.
- Codes:
  - ADD=0000, SUB=0001, PASS=0011 (result=op_b).
  - OR=0100, AND=0101, XOR=0111.
  - SRL=1000, SLL=1001, SRA=1010.
  - SLT=1101, SLTU=1111.
  - Any other code: result=0, flags as computed from result=0.
- Arithmetic:
  - SUB is op_a + ~op_b + 1; cf is the raw adder carry-out.
  - vf is set for ADD when both operands have the same sign and the result sign differs; for SUB when the operand signs differ and the result sign differs from op_a.
  - SLT is a signed compare; SLTU is an unsigned compare. Both produce result 0 or 1, zero-extended.
- States:
  - IDLE: in_ready=1.
    - Accept on in_valid & in_ready at edge k.
    - Non-shift op, or shift with amount 0: result/flags registered at edge k, go to DONE. out_valid is high the cycle after edge k (1-cycle latency).
    - Shift with amount n>0: load op_a into the shift register and n into the counter, go to SHIFT.
  - SHIFT: in_ready=0.
    - Each edge shifts one bit (SRL fills 0, SLL fills 0, SRA fills the sign bit) and decrements the counter.
    - The edge that brings the counter from 1 to 0 goes to DONE. out_valid rises after edge k+n, giving latency n+1 cycles from the accept edge.
  - DONE: out_valid=1, in_ready=0. result/flags stable.
    - On out_ready=1: go to IDLE at that edge. in_ready=1 the next cycle; no same-cycle back-to-back accept.
    - out_ready=0: hold indefinitely.
- Flags for shifts are evaluated on the final shifted value.
- in_valid while in_ready=0 is ignored; the producer must hold its inputs until in_ready.
- op_a/op_b/alu_sel changing after acceptance does not affect the operation in flight.

Optional Feature:
- SEQ_ALU_FAST_SHIFT_EN defined:
  - Shifts complete in a single barrel step, with the same timing as non-shift ops (1-cycle latency). The SHIFT state and counter are not instantiated.
- Not defined:
  - Bit-serial shifting as described above, with latency n+1.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT (SLL, amount 20, after 5 cycles) -> out_valid=0, result=0, zf=1 immediately. in_ready=1 after release.
- ADD overflow: op_a=0x7FFFFFFF, op_b=1, ADD -> result=0x80000000, vf=1, cf=0, sf=1, zf=0, out_valid one cycle after accept.
- SUB equal: op_a=op_b=0x12345678, SUB -> result=0, zf=1, cf=1, vf=0. Then SLTU with op_a=1, op_b=0xFFFFFFFF -> result=1.
- SRA serial: op_a=0x80000000, op_b=4, SRA -> result=0xF8000000, out_valid rises 5 cycles after accept. Same with amount 0 -> 1-cycle latency, result=op_a.
- Backpressure: complete an XOR with out_ready=0 for 10 cycles -> result/flags stable, in_ready=0, a new in_valid is ignored. On out_ready=1 -> IDLE, next op accepted.
- Undefined code 0110: op_a=5, op_b=3 -> result=0, zf=1. With SEQ_ALU_FAST_SHIFT_EN, SLL of 1 by 31 -> 0x80000000 in 1 cycle.
